// File: rtl/rice_core_if_stage.sv
// Instruction-fetch stage: issues in-order word fetches under a credit limit and
// delivers {valid, pc, inst} to decode through a small in-order buffer.
module rice_core_if_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_enable,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  output logic            o_inst_request_valid,
  input  logic            i_inst_request_ready,
  output logic [XLEN-1:0] o_inst_request_address,
  input  logic            i_inst_response_valid,
  input  logic [31:0]     i_inst_response_data,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [31:0]     o_if_inst
);

  localparam int              CW        = $clog2(DEPTH + 1);
  localparam int              PW        = $clog2(DEPTH);
  localparam logic [CW:0]     DEPTH_LIM = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] response_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_count;
  logic [CW-1:0]   buf_count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] buf_pc   [DEPTH];
  logic [31:0]     buf_inst [DEPTH];

  logic            credit_ok;
  logic            req_fire;
  logic            resp_drop;
  logic            resp_keep;
  logic            load_out;
  logic            pop;
  logic            bypass;
  logic            push;
  logic [XLEN-1:0] flush_target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit covers in-flight fetches (including ones to be dropped) plus buffered words,
  // so the buffer can never overflow.
  assign credit_ok              = ({1'b0, outstanding} + {1'b0, buf_count}) < DEPTH_LIM;
  assign o_inst_request_valid   = !i_rst && i_enable && !i_flush && credit_ok;
  assign o_inst_request_address = fetch_pc & WORD_MASK;
  assign req_fire               = o_inst_request_valid && i_inst_request_ready;

  assign resp_drop    = i_inst_response_valid && (i_flush || (drop_count != '0));
  assign resp_keep    = i_inst_response_valid && !resp_drop;
  assign load_out     = !i_flush && !i_stall && i_enable;
  assign pop          = load_out && (buf_count != '0);
  assign bypass       = load_out && (buf_count == '0) && resp_keep;
  assign push         = resp_keep && !bypass;
  assign flush_target = i_flush_pc & WORD_MASK;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC;
      response_pc <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
      buf_count   <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      o_if_valid  <= 1'b0;
      o_if_pc     <= '0;
      o_if_inst   <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(i_inst_response_valid);
      if (i_flush) begin
        fetch_pc    <= flush_target;
        response_pc <= flush_target;
        drop_count  <= outstanding - CW'(i_inst_response_valid);
        buf_count   <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        o_if_valid  <= 1'b0;
      end else begin
        if (req_fire)  fetch_pc    <= fetch_pc + PC_STEP;
        if (resp_drop) drop_count  <= drop_count - CW'(1);
        if (resp_keep) response_pc <= response_pc + PC_STEP;
        if (push)      wr_ptr      <= ptr_inc(wr_ptr);
        if (pop)       rd_ptr      <= ptr_inc(rd_ptr);
        buf_count <= buf_count + CW'(push) - CW'(pop);
        if (!i_stall) begin
          if (pop) begin
            o_if_valid <= 1'b1;
            o_if_pc    <= buf_pc[rd_ptr];
            o_if_inst  <= buf_inst[rd_ptr];
          end else if (bypass) begin
            o_if_valid <= 1'b1;
            o_if_pc    <= response_pc;
            o_if_inst  <= i_inst_response_data;
          end else begin
            o_if_valid <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= response_pc;
      buf_inst[wr_ptr] <= i_inst_response_data;
    end
  end

endmodule

// File: tb/tb_rice_core_if_stage.sv
// Directed bench for rice_core_if_stage: a queued fetch-bus model answers each accepted
// request one cycle later with data = ~address; outputs are checked after each edge.
module tb_rice_core_if_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_flush_pc;
  logic        o_inst_request_valid;
  logic        i_inst_request_ready;
  logic [31:0] o_inst_request_address;
  logic        i_inst_response_valid;
  logic [31:0] i_inst_response_data;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_inst;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acc   = 0;
  int          n0;
  logic        resp_en;
  logic        req_v_s;
  logic [31:0] req_a_s;
  logic [31:0] exp_pc;
  logic [31:0] q[$];

  rice_core_if_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_enable               (i_enable),
    .i_stall                (i_stall),
    .i_flush                (i_flush),
    .i_flush_pc             (i_flush_pc),
    .o_inst_request_valid   (o_inst_request_valid),
    .i_inst_request_ready   (i_inst_request_ready),
    .o_inst_request_address (o_inst_request_address),
    .i_inst_response_valid  (i_inst_response_valid),
    .i_inst_response_data   (i_inst_response_data),
    .o_if_valid             (o_if_valid),
    .o_if_pc                (o_if_pc),
    .o_if_inst              (o_if_inst)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: sample the request channel, clock, then drive next response.
  task automatic tick();
    logic acc;
    #1;
    req_v_s = o_inst_request_valid;
    req_a_s = o_inst_request_address;
    acc     = req_v_s && i_inst_request_ready;
    @(posedge i_clk);
    if (acc) begin
      q.push_back(req_a_s);
      n_acc++;
    end
    #1;
    if (i_rst) q.delete();
    if (resp_en && !i_rst && q.size() > 0) begin
      i_inst_response_valid = 1'b1;
      i_inst_response_data  = ~q.pop_front();
    end else begin
      i_inst_response_valid = 1'b0;
      i_inst_response_data  = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_enable = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_flush_pc = '0;
    i_inst_request_ready = 1'b1; i_inst_response_valid = 1'b0; i_inst_response_data = '0;
    resp_en = 1'b1;

    tick();
    check("rst_req_valid", {31'b0, req_v_s}, 32'd0);
    check("rst_if_valid", {31'b0, o_if_valid}, 32'd0);
    check("rst_if_pc", o_if_pc, 32'h0);
    check("rst_if_inst", o_if_inst, 32'h0);

    i_rst = 1'b0;
    tick();
    check("first_req_valid", {31'b0, req_v_s}, 32'd1);
    check("first_req_addr", req_a_s, 32'h0);
    check("first_if_valid", {31'b0, o_if_valid}, 32'd0);

    exp_pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stream_valid", {31'b0, o_if_valid}, 32'd1);
      check("stream_pc", o_if_pc, exp_pc);
      check("stream_inst", o_if_inst, ~exp_pc);
      exp_pc += 32'd4;
    end

    i_stall = 1'b1;
    n0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'b0, o_if_valid}, 32'd1);
      check("stall_pc", o_if_pc, 32'h14);
      check("stall_inst", o_if_inst, ~32'h14);
    end
    check("stall_req_count", 32'(n_acc - n0), 32'd1);

    i_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("unstall_valid", {31'b0, o_if_valid}, 32'd1);
      check("unstall_pc", o_if_pc, exp_pc);
      check("unstall_inst", o_if_inst, ~exp_pc);
      exp_pc += 32'd4;
    end

    i_inst_request_ready = 1'b0;
    tick();
    check("rdylo_drain_pc", o_if_pc, 32'h28);
    check("rdylo_req_valid", {31'b0, req_v_s}, 32'd1);
    check("rdylo_req_addr", req_a_s, 32'h2c);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rdylo_hold_valid", {31'b0, req_v_s}, 32'd1);
      check("rdylo_hold_addr", req_a_s, 32'h2c);
      check("rdylo_if_valid", {31'b0, o_if_valid}, 32'd0);
    end

    resp_en = 1'b0;
    i_inst_request_ready = 1'b1;
    tick();
    check("out2_req_a", req_a_s, 32'h2c);
    tick();
    check("out2_req_b", req_a_s, 32'h30);

    i_flush = 1'b1; i_flush_pc = 32'h100; resp_en = 1'b1;
    tick();
    check("flush1_req_valid", {31'b0, req_v_s}, 32'd0);
    check("flush1_drop_count", 32'(dut.drop_count), 32'd2);
    check("flush1_if_valid", {31'b0, o_if_valid}, 32'd0);
    i_flush = 1'b0;
    tick();
    check("drop1_req_valid", {31'b0, req_v_s}, 32'd0);
    check("drop1_if_valid", {31'b0, o_if_valid}, 32'd0);
    tick();
    check("drop2_req_valid", {31'b0, req_v_s}, 32'd1);
    check("drop2_req_addr", req_a_s, 32'h100);
    check("drop2_if_valid", {31'b0, o_if_valid}, 32'd0);
    tick();
    check("redirect_valid", {31'b0, o_if_valid}, 32'd1);
    check("redirect_pc", o_if_pc, 32'h100);
    check("redirect_inst", o_if_inst, ~32'h100);

    resp_en = 1'b0;
    tick();
    check("redirect2_pc", o_if_pc, 32'h104);
    resp_en = 1'b1;
    tick();
    check("build_req_addr", req_a_s, 32'h10c);
    check("build_if_valid", {31'b0, o_if_valid}, 32'd0);

    i_flush = 1'b1; i_flush_pc = 32'h203;
    tick();
    check("flush2_req_valid", {31'b0, req_v_s}, 32'd0);
    check("flush2_drop_count", 32'(dut.drop_count), 32'd1);
    check("flush2_if_valid", {31'b0, o_if_valid}, 32'd0);
    i_flush = 1'b0;
    tick();
    check("flush2_req_valid2", {31'b0, req_v_s}, 32'd1);
    check("flush2_req_addr", req_a_s, 32'h200);
    check("flush2_drop_done", 32'(dut.drop_count), 32'd0);
    tick();
    check("flush2_pc", o_if_pc, 32'h200);
    check("flush2_inst", o_if_inst, ~32'h200);

    i_flush = 1'b1; i_flush_pc = 32'hffff_fff8;
    tick();
    check("flush3_drop_count", 32'(dut.drop_count), 32'd0);
    i_flush = 1'b0;
    tick();
    check("wrap_req_f8", req_a_s, 32'hffff_fff8);
    tick();
    check("wrap_pc_f8", o_if_pc, 32'hffff_fff8);
    check("wrap_req_fc", req_a_s, 32'hffff_fffc);
    tick();
    check("wrap_pc_fc", o_if_pc, 32'hffff_fffc);
    check("wrap_req_0", req_a_s, 32'h0);
    tick();
    check("wrap_pc_0", o_if_pc, 32'h0);
    check("wrap_inst_0", o_if_inst, 32'hffff_ffff);
    check("wrap_valid_0", {31'b0, o_if_valid}, 32'd1);

    i_rst = 1'b1;
    #1;
    check("midrst_if_valid", {31'b0, o_if_valid}, 32'd0);
    check("midrst_if_pc", o_if_pc, 32'h0);
    check("midrst_if_inst", o_if_inst, 32'h0);
    check("midrst_req_valid", {31'b0, o_inst_request_valid}, 32'd0);
    tick();
    i_rst = 1'b0;
    tick();
    check("restart_req_valid", {31'b0, req_v_s}, 32'd1);
    check("restart_req_addr", req_a_s, 32'h0);
    tick();
    check("restart_pc", o_if_pc, 32'h0);
    check("restart_valid", {31'b0, o_if_valid}, 32'd1);

    i_enable = 1'b0;
    tick();
    check("disable_req_valid", {31'b0, req_v_s}, 32'd0);
    check("disable_if_valid", {31'b0, o_if_valid}, 32'd0);
    i_enable = 1'b1;
    tick();
    check("reenable_pc", o_if_pc, 32'h4);
    check("reenable_valid", {31'b0, o_if_valid}, 32'd1);
    tick();
    check("reenable_pc2", o_if_pc, 32'h8);
    check("reenable_inst2", o_if_inst, ~32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
